prog_loader: RTL

Byte-stream program loader sitting directly upstream of the `mips32` core. It accepts framed command bytes over a valid/ready byte interface, assembles 32-bit words, and drives the core's `mode`/`w_addr`/`in_data` load port to fill instruction or data memory. It then releases the core into run mode, replacing testbench-driven memory preloading with a synthesizable path, e.g. behind a UART receiver.

---
 rtl/prog_loader.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// Byte-stream program loader: parses I/D/G command frames from a valid/ready byte
// stream and drives the mips32 load port (mode/w_addr/in_data), then releases the core.
module prog_loader (
    input  logic        clk_x,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [1:0]  mode,
    output logic [31:0] w_addr,
    output logic [31:0] in_data,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [7:0] CMD_INST = 8'h49;
    localparam logic [7:0] CMD_DATA = 8'h44;
    localparam logic [7:0] CMD_GO   = 8'h47;

    localparam logic [1:0] MODE_RUN  = 2'b00;
    localparam logic [1:0] MODE_DATA = 2'b01;
    localparam logic [1:0] MODE_INST = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_CNT, S_DATA, S_WRITE, S_CSUM, S_RUN
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  tgt_q, tgt_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] word_q, word_d;
    logic [7:0]  csum_q, csum_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic        err_q, err_d;
    logic        rdy_q, rdy_d;
    logic [1:0]  mode_q, mode_d;
    logic [31:0] waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        take;

    // Core only ever sees a write mode during the single WRITE cycle.
    function automatic logic [1:0] mode_for(input state_t st, input logic [1:0] tgt);
        case (st)
            S_WRITE: mode_for = tgt;
            S_RUN:   mode_for = MODE_RUN;
            default: mode_for = MODE_HOLD;
        endcase
    endfunction

    assign take = rx_valid && rdy_q;

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        csum_d  = csum_q;
        bcnt_d  = bcnt_q;
        err_d   = err_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;

        case (state_q)
            S_IDLE: begin
                if (take) begin
                    if (rx_data == CMD_INST || rx_data == CMD_DATA) begin
                        tgt_d   = (rx_data == CMD_INST) ? MODE_INST : MODE_DATA;
                        csum_d  = 8'h00;
                        bcnt_d  = 2'd0;
                        state_d = S_ADDR;
                    end else if (rx_data == CMD_GO) begin
                        state_d = S_RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_ADDR: begin
                if (take) begin
                    addr_d = {addr_q[23:0], rx_data};
                    csum_d = csum_q ^ rx_data;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) state_d = S_CNT;
                end
            end
            S_CNT: begin
                if (take) begin
                    cnt_d  = {cnt_q[7:0], rx_data};
                    csum_d = csum_q ^ rx_data;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd1) begin
                        bcnt_d  = 2'd0;
                        state_d = ({cnt_q[7:0], rx_data} == 16'd0) ? S_CSUM : S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (take) begin
                    word_d = {word_q[23:0], rx_data};
                    csum_d = csum_q ^ rx_data;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // cnt_q >= 1 here, so the decrement can never underflow.
                addr_d  = addr_q + 32'd1;
                cnt_d   = cnt_q - 16'd1;
                state_d = (cnt_q == 16'd1) ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
                if (take) begin
                    if (rx_data != csum_q) err_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_RUN:   state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase

        rdy_d  = (state_d inside {S_IDLE, S_ADDR, S_CNT, S_DATA, S_CSUM});
        busy_d = !(state_d inside {S_IDLE, S_RUN});
        done_d = (state_d == S_RUN);
        mode_d = mode_for(state_d, tgt_d);
        if (state_d == S_WRITE) begin
            waddr_d = addr_q;
            wdata_d = word_d;
        end
    end

    always_ff @(posedge clk_x) begin
        if (rst) begin
            state_q <= S_IDLE;
            tgt_q   <= MODE_HOLD;
            addr_q  <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            csum_q  <= '0;
            bcnt_q  <= '0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
            mode_q  <= MODE_HOLD;
            waddr_q <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            csum_q  <= csum_d;
            bcnt_q  <= bcnt_d;
            err_q   <= err_d;
            rdy_q   <= rdy_d;
            mode_q  <= mode_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign rx_ready = rdy_q;
    assign mode     = mode_q;
    assign w_addr   = waddr_q;
    assign in_data  = wdata_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule
